// File: rtl/ccd_binarize_stage.sv
// CCD RGB stream -> 300x150 one-bit image writer: crop, decimate, luma, threshold, one frame per START.
// Optional BIN_COUNT_EN adds WHITE_CNT, the number of white samples written in the last captured frame.
module ccd_binarize_stage #(
  parameter int X0       = 20,
  parameter int Y0       = 90,
  parameter int DEC_LOG2 = 1,
  parameter int OUT_W    = 300,
  parameter int OUT_H    = 150,
  parameter int THRESH   = 512
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [9:0]  iX,
  input  logic [9:0]  iY,
  input  logic [9:0]  iR,
  input  logic [9:0]  iG,
  input  logic [9:0]  iB,
  output logic        WE,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic        eachConf,
`ifdef BIN_COUNT_EN
  output logic [15:0] WHITE_CNT,
`endif
  output logic        BUSY,
  output logic        DONE
);

  localparam int DEC = 1 << DEC_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_FLUSH} state_t;

  typedef struct packed {
    logic [9:0] luma;
    logic [9:0] xo;
    logic [9:0] yo;
  } s1_t;

  state_t      state, state_nxt;
  logic        fval_prev, rise, fall;
  logic        fl_cnt, done;
  logic [2:1]  vld_pipe;
  s1_t         s1;

  logic signed [10:0] dx, dy;
  logic               in_win, samp;
  logic [17:0]        lsum;

  assign rise = iFVAL & ~fval_prev;
  assign fall = ~iFVAL & fval_prev;

  // Crop offsets are signed so pixels left/above the window fall out as negative.
  assign dx = $signed({1'b0, iX}) - $signed(11'(X0));
  assign dy = $signed({1'b0, iY}) - $signed(11'(Y0));

  assign in_win = !dx[10] && !dy[10]
               && ($unsigned(dx) < 11'(OUT_W << DEC_LOG2))
               && ($unsigned(dy) < 11'(OUT_H << DEC_LOG2))
               && (($unsigned(dx) & 11'(DEC - 1)) == 11'd0)
               && (($unsigned(dy) & 11'(DEC - 1)) == 11'd0);

  assign samp = (state == S_CAP) && iDVAL && in_win;

  // Weights sum to 256, so full-scale RGB maps to full-scale 10-bit luma.
  assign lsum = 18'd77 * {8'd0, iR} + 18'd150 * {8'd0, iG} + 18'd29 * {8'd0, iB};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_ARM;
      S_ARM:   if (rise)  state_nxt = S_CAP;
      S_CAP:   if (fall)  state_nxt = S_FLUSH;
      S_FLUSH: if (fl_cnt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      fval_prev <= 1'b0;
      fl_cnt    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fval_prev <= iFVAL;
      fl_cnt    <= (state == S_FLUSH) ? ~fl_cnt : 1'b0;
      done      <= (state == S_FLUSH) && fl_cnt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_pipe <= '0;
      s1       <= '0;
      X        <= '0;
      Y        <= '0;
      eachConf <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], samp};
      if (samp) begin
        s1.luma <= 10'(lsum >> 8);
        s1.xo   <= 10'($unsigned(dx) >> DEC_LOG2);
        s1.yo   <= 10'($unsigned(dy) >> DEC_LOG2);
      end
      // Outputs hold their last value between writes.
      if (vld_pipe[1]) begin
        X        <= s1.xo;
        Y        <= s1.yo;
        eachConf <= (s1.luma >= 10'(THRESH));
      end
    end
  end

  assign WE   = vld_pipe[2];
  assign BUSY = (state != S_IDLE);
  assign DONE = done;

`ifdef BIN_COUNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                        WHITE_CNT <= '0;
    else if (state == S_ARM && rise)  WHITE_CNT <= '0;
    else if (WE && eachConf)          WHITE_CNT <= WHITE_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ccd_binarize_stage.sv
// Directed bench for ccd_binarize_stage: reset, idle frame, window corners, mid-frame START,
// full uniform frame coverage, mid-capture reset, and WHITE_CNT when BIN_COUNT_EN is defined.
module tb_ccd_binarize_stage;
  logic       CLK = 0, RESET = 1, START = 0, iFVAL = 0, iDVAL = 0;
  logic [9:0] iX = 0, iY = 0, iR = 0, iG = 0, iB = 0;
  logic       WE, eachConf, BUSY, DONE;
  logic [9:0] X, Y;
`ifdef BIN_COUNT_EN
  logic [15:0] WHITE_CNT;
`endif

  ccd_binarize_stage dut (
    .CLK(CLK), .RESET(RESET), .START(START), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
    .WE(WE), .X(X), .Y(Y), .eachConf(eachConf),
`ifdef BIN_COUNT_EN
    .WHITE_CNT(WHITE_CNT),
`endif
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int we_tot = 0, blk_tot = 0, done_tot = 0, dup_tot = 0, oor_tot = 0, uniq_tot = 0;
  int tag = 1;
  int seen [300][150];

  // Write-port scoreboard: totals plus per-frame coverage of every (X,Y).
  always @(negedge CLK) begin
    if (WE) begin
      we_tot++;
      if (!eachConf) blk_tot++;
      if (X >= 300 || Y >= 150) oor_tot++;
      else if (seen[X][Y] == tag) dup_tot++;
      else begin
        seen[X][Y] = tag;
        uniq_tot++;
      end
    end
    if (DONE) done_tot++;
  end

  task automatic chk(input string name, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic px(input int x, input int y, input int c);
    @(negedge CLK);
    iDVAL = 1; iX = 10'(x); iY = 10'(y);
    iR = 10'(c); iG = 10'(c); iB = 10'(c);
    @(negedge CLK);
    iDVAL = 0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int found = 0;
    for (int k = 0; k < lim && found == 0; k++) begin
      @(negedge CLK);
      if (DONE) found = 1;
    end
    chk(name, found, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int w0, d0, b0, u0;

  initial begin
    // Reset state
    idle(3);
    chk("rst_we", WE, 0);     chk("rst_x", X, 0);       chk("rst_y", Y, 0);
    chk("rst_conf", eachConf, 0); chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0);
`ifdef BIN_COUNT_EN
    chk("rst_wcnt", WHITE_CNT, 0);
`endif
    @(negedge CLK); RESET = 0;
    idle(2);

    // Frame without START
    w0 = we_tot; d0 = done_tot;
    @(negedge CLK); iFVAL = 1;
    px(20, 90, 1023); px(100, 100, 1023); px(618, 388, 1023);
    @(negedge CLK); iFVAL = 0;
    idle(5);
    chk("idle_we", we_tot - w0, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_done", done_tot - d0, 0);

    // Directed window boundaries
    w0 = we_tot; d0 = done_tot;
    @(negedge CLK); START = 1;
    @(negedge CLK); START = 0;
    chk("arm_busy", BUSY, 1);
    iFVAL = 1;
    idle(2);
    px(20, 90, 600);
    chk("lat_we1", WE, 0);
    @(negedge CLK);
    chk("org_we", WE, 1); chk("org_x", X, 0); chk("org_y", Y, 0); chk("org_conf", eachConf, 1);
    px(21, 90, 600);   @(negedge CLK); chk("odd_x_we", WE, 0);
    px(619, 389, 600); @(negedge CLK); chk("odd_xy_we", WE, 0);
    px(620, 388, 600); @(negedge CLK); chk("x_over_we", WE, 0);
    px(618, 19, 600);  @(negedge CLK); chk("y_neg_we", WE, 0);
    px(618, 390, 600); @(negedge CLK); chk("y_over_we", WE, 0);
    // Last sample still in stage 1 when the frame ends
    px(618, 388, 511);
    iFVAL = 0;
    @(negedge CLK);
    chk("far_we", WE, 1); chk("far_x", X, 299); chk("far_y", Y, 149); chk("far_conf", eachConf, 0);
    chk("far_busy", BUSY, 1);
    wait_done("dir_done", 10);
    idle(3);
    chk("dir_we_cnt", we_tot - w0, 2);
    chk("dir_done_cnt", done_tot - d0, 1);
    chk("dir_busy_end", BUSY, 0);

    // START coincident with a rising iFVAL: that frame is skipped
    w0 = we_tot; d0 = done_tot;
    @(negedge CLK); iFVAL = 1; START = 1;
    @(negedge CLK); START = 0;
    px(20, 90, 1023); px(300, 200, 1023);
    @(negedge CLK); iFVAL = 0;
    idle(6);
    chk("mid_we", we_tot - w0, 0);
    chk("mid_done", done_tot - d0, 0);
    chk("mid_busy", BUSY, 1);

    // Next full uniform white frame, only decimated sample positions driven
    tag = 2;
    w0 = we_tot; d0 = done_tot; b0 = blk_tot; u0 = uniq_tot;
    @(negedge CLK); iFVAL = 1;
    iR = 1023; iG = 1023; iB = 1023;
    for (int y = 0; y < 150; y++)
      for (int x = 0; x < 300; x++) begin
        @(negedge CLK);
        iDVAL = 1; iX = 10'(20 + 2 * x); iY = 10'(90 + 2 * y);
      end
    @(negedge CLK); iDVAL = 0; iFVAL = 0;
    wait_done("uni_done", 10);
    idle(3);
    chk("uni_we_cnt", we_tot - w0, 45000);
    chk("uni_black", blk_tot - b0, 0);
    chk("uni_uniq", uniq_tot - u0, 45000);
    chk("uni_dup", dup_tot, 0);
    chk("uni_oor", oor_tot, 0);
    chk("uni_done_cnt", done_tot - d0, 1);
`ifdef BIN_COUNT_EN
    chk("uni_wcnt", WHITE_CNT, 45000);
`endif

    // Reset in the middle of capture
    d0 = done_tot;
    @(negedge CLK); START = 1;
    @(negedge CLK); START = 0; iFVAL = 1;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      iDVAL = 1; iX = 10'(20 + 2 * i); iY = 10'd100;
    end
    chk("pre_rst_we", WE, 1);
    RESET = 1;
    #1 chk("rst_async_we", WE, 0);
    @(negedge CLK);
    chk("rst_mid_we", WE, 0);
    chk("rst_mid_busy", BUSY, 0);
    w0 = we_tot;
    RESET = 0;
    @(negedge CLK); iDVAL = 0; iFVAL = 0;
    idle(8);
    chk("rst_mid_done", done_tot - d0, 0);
    chk("rst_mid_we_after", we_tot - w0, 0);

`ifdef BIN_COUNT_EN
    // Left half white, right half black (black half sampled on the first rows only)
    @(negedge CLK); START = 1;
    @(negedge CLK); START = 0; iFVAL = 1;
    idle(1);
    for (int y = 0; y < 150; y++)
      for (int x = 0; x < 300; x++)
        if (x < 150 || y < 10) begin
          @(negedge CLK);
          iDVAL = 1; iX = 10'(20 + 2 * x); iY = 10'(90 + 2 * y);
          iR = (x < 150) ? 10'd1023 : 10'd0; iG = iR; iB = iR;
        end
    @(negedge CLK); iDVAL = 0; iFVAL = 0;
    wait_done("cnt_done", 10);
    chk("cnt_wcnt", WHITE_CNT, 22500);
    idle(3);
    chk("cnt_hold", WHITE_CNT, 22500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
